// File: rtl/ram_writer_multi.sv
// Multi-channel AXI-Stream to DDR ring-buffer writer: decimates, then writes each lane
// into its own ring via single-beat AXI4 writes, with post-trigger capture and overrun flag.
module ram_writer_multi #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int CHANNELS       = 2,
    parameter int MAX_LOG_LENGTH = 20
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic                           request,
    input  logic [4:0]                     log_length,
    input  logic [4:0]                     log_throttle,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic                           s_axis_tvalid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DATA_WIDTH-1:0]          m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [MAX_LOG_LENGTH-1:0]      write_ptr,
    output logic [MAX_LOG_LENGTH-1:0]      trigger_ptr,
    output logic                           done,
    output logic                           overrun
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                         state;
    logic                           enable_q, request_q;
    logic [4:0]                     len_q, thr_q, len_clamped;
    logic [ADDR_WIDTH-1:0]          base_q;
    logic [31:0]                    thr_cnt, thr_mask;
    logic [CHANNELS*DATA_WIDTH-1:0] sample_q;
    logic [CH_W-1:0]                ch, next_ch;
    logic [MAX_LOG_LENGTH-1:0]      post_count, post_load, pc_cur, ptr_next;
    logic [MAX_LOG_LENGTH:0]        ptr_span;
    logic                           post_active, active_cur;
    logic                           aw_done, w_done, aw_hs, w_hs, ch_complete, last_ch;
    logic                           enable_rise, request_rise, request_fall, trig;
    logic                           beat_counted, sel;
    logic [ADDR_WIDTH-1:0]          addr_next;
    logic [DATA_WIDTH-1:0]          wdata_next;
    logic [DATA_WIDTH-1:0]          lanes [CHANNELS];
    logic                           unused_bvalid;

    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = 1'b1;
    assign unused_bvalid = m_axi_bvalid;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        len_clamped = log_length;
        if (log_length == 5'd0)
            len_clamped = 5'd1;
        else if (log_length > 5'(MAX_LOG_LENGTH))
            len_clamped = 5'(MAX_LOG_LENGTH);

        for (int c = 0; c < CHANNELS; c++)
            lanes[c] = sample_q[c*DATA_WIDTH +: DATA_WIDTH];

        enable_rise  = enable & ~enable_q & (state != S_WRITE);
        request_rise = request & ~request_q;
        request_fall = ~request & request_q;
        trig         = request_rise & ~post_active & ~enable_rise
                       & ((state == S_WAIT) | (state == S_WRITE));

        thr_mask     = (32'd1 << thr_q) - 32'd1;
        beat_counted = enable & ~enable_rise & s_axis_tvalid & (state != S_IDLE);
        sel          = beat_counted & (thr_cnt == 32'd0);

        aw_hs       = m_axi_awvalid & m_axi_awready;
        w_hs        = m_axi_wvalid & m_axi_wready;
        ch_complete = (aw_done | aw_hs) & (w_done | w_hs);
        last_ch     = (ch == CH_W'(CHANNELS - 1));

        next_ch    = (state == S_WAIT) ? '0 : ch + CH_W'(1);
        addr_next  = base_q + ((ADDR_WIDTH'(next_ch) << len_q) + ADDR_WIDTH'(write_ptr))
                     * ADDR_WIDTH'(BYTES);
        wdata_next = (state == S_WAIT) ? s_axis_tdata[DATA_WIDTH-1:0] : lanes[next_ch];

        ptr_span  = (MAX_LOG_LENGTH+1)'(1) << len_q;
        ptr_next  = (write_ptr + MAX_LOG_LENGTH'(1)) & (ptr_span[MAX_LOG_LENGTH-1:0] - MAX_LOG_LENGTH'(1));
        post_load = MAX_LOG_LENGTH'(1) << (len_q - 5'd1);
        // A trigger on the completion cycle lets that sample count immediately.
        pc_cur     = trig ? post_load : post_count;
        active_cur = trig | post_active;
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments override earlier ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            enable_q      <= 1'b0;
            request_q     <= 1'b0;
            len_q         <= 5'd1;
            thr_q         <= 5'd0;
            base_q        <= '0;
            thr_cnt       <= '0;
            sample_q      <= '0;
            ch            <= '0;
            post_count    <= '0;
            post_active   <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            write_ptr     <= '0;
            trigger_ptr   <= '0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            enable_q  <= enable;
            request_q <= request;
            if (beat_counted)
                thr_cnt <= (thr_cnt + 32'd1) & thr_mask;
            if (sel && state != S_WAIT)
                overrun <= 1'b1;
            if (trig) begin
                trigger_ptr <= write_ptr;
                post_count  <= post_load;
                post_active <= 1'b1;
            end

            if (enable_rise) begin
                len_q       <= len_clamped;
                thr_q       <= log_throttle;
                base_q      <= base_addr;
                write_ptr   <= '0;
                thr_cnt     <= '0;
                done        <= 1'b0;
                overrun     <= 1'b0;
                post_active <= 1'b0;
                state       <= S_WAIT;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (sel) begin
                            sample_q      <= s_axis_tdata;
                            ch            <= '0;
                            m_axi_awaddr  <= addr_next;
                            m_axi_wdata   <= wdata_next;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (aw_hs) begin
                            m_axi_awvalid <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (w_hs) begin
                            m_axi_wvalid <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if (ch_complete) begin
                            if (!enable) begin
                                state <= S_IDLE;
                            end else if (!last_ch) begin
                                ch            <= next_ch;
                                m_axi_awaddr  <= addr_next;
                                m_axi_wdata   <= wdata_next;
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                            end else begin
                                write_ptr <= ptr_next;
                                state     <= S_WAIT;
                                if (active_cur) begin
                                    post_count <= pc_cur - MAX_LOG_LENGTH'(1);
                                    if (pc_cur == MAX_LOG_LENGTH'(1)) begin
                                        post_active <= 1'b0;
                                        done        <= 1'b1;
                                        state       <= S_DONE;
                                    end
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (request_fall) begin
                            done  <= 1'b0;
                            state <= S_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ram_writer_multi.sv
// Directed bench for ram_writer_multi: table-driven address/data vectors plus
// hand-written throttle, overrun, trigger, backpressure, enable-drop and reset sequences.
module tb_ram_writer_multi;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int CH  = 2;
    localparam int MLL = 20;

    logic              aclk, aresetn, enable, request;
    logic [4:0]        log_length, log_throttle;
    logic [AW-1:0]     base_addr;
    logic              s_axis_tvalid;
    logic [CH*DW-1:0]  s_axis_tdata;
    logic [AW-1:0]     m_axi_awaddr;
    logic              m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic [MLL-1:0]    write_ptr, trigger_ptr;
    logic              done, overrun;

    ram_writer_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH), .MAX_LOG_LENGTH(MLL)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .request(request),
        .log_length(log_length), .log_throttle(log_throttle), .base_addr(base_addr),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .write_ptr(write_ptr), .trigger_ptr(trigger_ptr), .done(done), .overrun(overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Accepted AW addresses and W data, observed mid-cycle ahead of the handshake edge.
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    always @(negedge aclk) begin
        if (aresetn && m_axi_awvalid && m_axi_awready) aw_q.push_back(m_axi_awaddr);
        if (aresetn && m_axi_wvalid && m_axi_wready) w_q.push_back(m_axi_wdata);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane_a(input int idx);
        return 32'hA000_0000 + DW'(idx);
    endfunction

    function automatic logic [DW-1:0] lane_b(input int idx);
        return 32'hB000_0000 + DW'(idx);
    endfunction

    task automatic start(input logic [4:0] len, input logic [4:0] thr, input logic [AW-1:0] base);
        enable = 1'b0;
        tick();
        log_length   = len;
        log_throttle = thr;
        base_addr    = base;
        enable       = 1'b1;
        tick();
        aw_q.delete();
        w_q.delete();
    endtask

    // One selected beat followed by enough idle cycles for both channels to drain.
    task automatic sample(input int idx);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(idx), lane_a(idx)};
        tick();
        s_axis_tvalid = 1'b0;
        repeat (CH + 1) tick();
    endtask

    typedef struct {
        logic [4:0]    len;
        logic [AW-1:0] base;
        int            skip;
        logic [AW-1:0] addr0;
        logic [AW-1:0] addr1;
        logic [MLL-1:0] wp_after;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5'd4,  32'h1000_0000, 0,  32'h1000_0000, 32'h1000_0040, 20'd1};
        vecs[1] = '{5'd4,  32'h1000_0000, 5,  32'h1000_0014, 32'h1000_0054, 20'd6};
        vecs[2] = '{5'd4,  32'h1000_0000, 15, 32'h1000_003C, 32'h1000_007C, 20'd0};
        vecs[3] = '{5'd0,  32'h0000_2000, 1,  32'h0000_2004, 32'h0000_200C, 20'd0};
        vecs[4] = '{5'd31, 32'h0000_0000, 0,  32'h0000_0000, 32'h0040_0000, 20'd1};
        vecs[5] = '{5'd2,  32'hFFFF_FFF0, 3,  32'hFFFF_FFFC, 32'h0000_000C, 20'd0};

        aresetn = 1'b0; enable = 1'b0; request = 1'b0;
        log_length = '0; log_throttle = '0; base_addr = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        repeat (3) tick();

        check("rst awvalid", m_axi_awvalid, 0);
        check("rst wvalid", m_axi_wvalid, 0);
        check("rst awaddr", m_axi_awaddr, 0);
        check("rst wdata", m_axi_wdata, 0);
        check("rst bready", m_axi_bready, 1);
        check("rst write_ptr", write_ptr, 0);
        check("rst trigger_ptr", trigger_ptr, 0);
        check("rst done", done, 0);
        check("rst overrun", overrun, 0);
        aresetn = 1'b1;
        tick();

        // Address/data vectors, including ring wrap, length clamps and address wrap.
        for (int i = 0; i < 6; i++) begin
            start(vecs[i].len, 5'd0, vecs[i].base);
            log_length = 5'd9;
            base_addr  = 32'h5555_0000;
            for (int k = 0; k < vecs[i].skip; k++) sample(k);
            aw_q.delete();
            w_q.delete();
            sample(100 + i);
            check($sformatf("v%0d aw count", i), aw_q.size(), 2);
            check($sformatf("v%0d w count", i), w_q.size(), 2);
            if (aw_q.size() == 2) begin
                check($sformatf("v%0d addr ch0", i), aw_q[0], vecs[i].addr0);
                check($sformatf("v%0d addr ch1", i), aw_q[1], vecs[i].addr1);
            end
            if (w_q.size() == 2) begin
                check($sformatf("v%0d data ch0", i), w_q[0], lane_a(100 + i));
                check($sformatf("v%0d data ch1", i), w_q[1], lane_b(100 + i));
            end
            check($sformatf("v%0d write_ptr", i), write_ptr, vecs[i].wp_after);
        end

        // Throttle by 8 with continuous valid: beats 0, 8, 16, 24 are written.
        start(5'd4, 5'd3, 32'h1000_0000);
        for (int b = 0; b < 32; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {lane_b(b), lane_a(b)};
            tick();
        end
        s_axis_tvalid = 1'b0;
        repeat (4) tick();
        check("thr aw count", aw_q.size(), 8);
        if (w_q.size() == 8) begin
            check("thr data beat8", w_q[2], lane_a(8));
            check("thr data beat24", w_q[7], lane_b(24));
        end
        check("thr write_ptr", write_ptr, 4);
        check("thr overrun", overrun, 0);

        // Overrun: second selected beat lands during WRITE.
        start(5'd4, 5'd0, 32'h1000_0000);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(0), lane_a(0)};
        tick();
        check("ovr first beat", overrun, 0);
        tick();
        check("ovr second beat", overrun, 1);
        repeat (4) tick();
        s_axis_tvalid = 1'b0;
        repeat (4) tick();
        check("ovr sticky", overrun, 1);
        start(5'd4, 5'd0, 32'h1000_0000);
        check("ovr cleared on enable", overrun, 0);

        // Trigger at write_ptr=5, post-count 8.
        start(5'd4, 5'd0, 32'h1000_0000);
        for (int k = 0; k < 5; k++) sample(k);
        check("trg pre write_ptr", write_ptr, 5);
        request = 1'b1;
        tick();
        check("trg trigger_ptr", trigger_ptr, 5);
        check("trg done early", done, 0);
        for (int k = 0; k < 3; k++) sample(k);
        request = 1'b0;
        tick();
        request = 1'b1;
        tick();
        check("trg retrigger ignored", trigger_ptr, 5);
        for (int k = 0; k < 4; k++) sample(k);
        check("trg wp before last", write_ptr, 12);
        check("trg done before last", done, 0);
        sample(7);
        check("trg done", done, 1);
        check("trg wp frozen", write_ptr, 13);
        aw_q.delete();
        sample(200);
        check("trg no write in done", aw_q.size(), 0);
        check("trg wp held", write_ptr, 13);
        request = 1'b0;
        tick();
        check("trg done cleared", done, 0);
        aw_q.delete();
        sample(201);
        check("trg resume aw count", aw_q.size(), 2);
        if (aw_q.size() == 2) check("trg resume addr", aw_q[0], 32'h1000_0034);
        check("trg resume wp", write_ptr, 14);
        check("trg ptr kept", trigger_ptr, 5);

        // Request edge coincident with a selected beat: that beat counts.
        request = 1'b0;
        start(5'd4, 5'd0, 32'h1000_0000);
        sample(0);
        sample(1);
        request       = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(2), lane_a(2)};
        tick();
        s_axis_tvalid = 1'b0;
        repeat (CH + 1) tick();
        check("sim trigger_ptr", trigger_ptr, 2);
        for (int k = 0; k < 6; k++) sample(k);
        check("sim done before last", done, 0);
        sample(9);
        check("sim done", done, 1);
        check("sim wp", write_ptr, 10);
        request = 1'b0;
        tick();

        // Backpressure on W while AW is ready.
        start(5'd4, 5'd0, 32'h1000_0000);
        m_axi_wready  = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(50), lane_a(50)};
        tick();
        s_axis_tvalid = 1'b0;
        check("bp c1 awvalid", m_axi_awvalid, 1);
        check("bp c1 wvalid", m_axi_wvalid, 1);
        check("bp c1 awaddr", m_axi_awaddr, 32'h1000_0000);
        tick();
        check("bp c2 awvalid", m_axi_awvalid, 0);
        check("bp c2 wvalid", m_axi_wvalid, 1);
        check("bp c2 wdata", m_axi_wdata, lane_a(50));
        tick();
        check("bp c3 awvalid", m_axi_awvalid, 0);
        check("bp c3 wvalid", m_axi_wvalid, 1);
        check("bp c3 wdata", m_axi_wdata, lane_a(50));
        m_axi_wready = 1'b1;
        tick();
        check("bp ch1 awvalid", m_axi_awvalid, 1);
        check("bp ch1 wvalid", m_axi_wvalid, 1);
        check("bp ch1 awaddr", m_axi_awaddr, 32'h1000_0040);
        check("bp ch1 wdata", m_axi_wdata, lane_b(50));
        tick();
        check("bp end awvalid", m_axi_awvalid, 0);
        check("bp end wp", write_ptr, 1);

        // Enable dropped during ch 0: finish the handshake, no ch 1.
        start(5'd4, 5'd0, 32'h1000_0000);
        m_axi_wready  = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(60), lane_a(60)};
        tick();
        s_axis_tvalid = 1'b0;
        enable        = 1'b0;
        tick();
        check("en held wvalid", m_axi_wvalid, 1);
        check("en aw dropped", m_axi_awvalid, 0);
        m_axi_wready = 1'b1;
        tick();
        check("en w dropped", m_axi_wvalid, 0);
        repeat (4) tick();
        check("en no ch1 aw", aw_q.size(), 1);
        check("en no ch1 w", w_q.size(), 1);
        check("en idle awvalid", m_axi_awvalid, 0);

        // Reset mid-write clears outputs asynchronously.
        start(5'd4, 5'd0, 32'h1000_0000);
        sample(0);
        sample(1);
        check("rstmid wp before", write_ptr, 2);
        m_axi_wready  = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {lane_b(70), lane_a(70)};
        tick();
        s_axis_tvalid = 1'b0;
        check("rstmid valid up", m_axi_wvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("rstmid awvalid", m_axi_awvalid, 0);
        check("rstmid wvalid", m_axi_wvalid, 0);
        check("rstmid awaddr", m_axi_awaddr, 0);
        check("rstmid wp", write_ptr, 0);
        check("rstmid bready", m_axi_bready, 1);
        m_axi_wready = 1'b1;
        #1 aresetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
